// File: rtl/seq_first_match_checker.sv
// In-silicon monitor for p ##1 q[*MIN_REP:MAX_REP] ##1 r |=> s[*S_LEN].
// Reports match/pass/fail/vacuous pulses and keeps saturating pass/fail counters.
module seq_first_match_checker #(
  parameter int unsigned MIN_REP     = 1,
  parameter int unsigned MAX_REP     = 3,
  parameter int unsigned S_LEN       = 2,
  parameter bit          FIRST_MATCH = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p,
  input  logic             q,
  input  logic             r,
  input  logic             s,
  output logic             match,
  output logic             pass,
  output logic             fail,
  output logic             vacuous,
  output logic             busy,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam int unsigned RepW = $clog2(MAX_REP + 1);
  localparam logic [RepW-1:0] MinRep = RepW'(MIN_REP);
  localparam logic [RepW-1:0] MaxRep = RepW'(MAX_REP);

  typedef enum logic [1:0] {StIdle, StArmed, StQrun, StCheck} state_e;

  state_e           state_q, state_d;
  logic [RepW-1:0]  rep_q, rep_d;
  logic [S_LEN-1:0] pend_q, pend_d;
  logic             hit_q, hit_d;
  logic             match_d, pass_d, fail_d, vacuous_d;
  logic             ep;

  always_comb begin
    state_d   = state_q;
    rep_d     = rep_q;
    pend_d    = pend_q;
    hit_d     = hit_q;
    match_d   = 1'b0;
    pass_d    = 1'b0;
    fail_d    = 1'b0;
    vacuous_d = 1'b0;
    ep        = (state_q == StQrun) && r && (rep_q >= MinRep);

    // One fail per event regardless of how many windows are outstanding.
    if (pend_q != '0) begin
      if (!s) begin
        fail_d = 1'b1;
        pend_d = '0;
      end else begin
        pass_d = pend_q[S_LEN-1];
        pend_d = pend_q << 1;
      end
    end

    if (ep) begin
      match_d   = 1'b1;
      hit_d     = 1'b1;
      pend_d[0] = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (p) state_d = StArmed;
      end
      StArmed: begin
        if (q) begin
          rep_d   = RepW'(1);
          hit_d   = 1'b0;
          state_d = StQrun;
        end else begin
          vacuous_d = 1'b1;
          state_d   = StIdle;
        end
      end
      StQrun: begin
        if (FIRST_MATCH && ep) begin
          state_d = StCheck;
        end else if (q && (rep_q < MaxRep)) begin
          rep_d = rep_q + RepW'(1);
        end else if ((pend_q != '0) || ep) begin
          state_d = StCheck;
        end else begin
          // A run that matched earlier but has drained is not vacuous.
          vacuous_d = !hit_q;
          state_d   = StIdle;
        end
      end
      StCheck: begin
        if (pend_d == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      rep_q    <= '0;
      pend_q   <= '0;
      hit_q    <= 1'b0;
      match    <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      vacuous  <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      state_q <= state_d;
      rep_q   <= rep_d;
      pend_q  <= pend_d;
      hit_q   <= hit_d;
      match   <= match_d;
      pass    <= pass_d;
      fail    <= fail_d;
      vacuous <= vacuous_d;
      if (pass_d && (pass_cnt != '1)) pass_cnt <= pass_cnt + CNT_W'(1);
      if (fail_d && (fail_cnt != '1)) fail_cnt <= fail_cnt + CNT_W'(1);
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_seq_first_match_checker.sv
// Bench for seq_first_match_checker: a first-match and an all-match instance share stimulus;
// a queue-based model is compared every cycle, plus hand-computed per-scenario expectations.
module tb_seq_first_match_checker;

  localparam int MinRep = 1;
  localparam int MaxRep = 3;
  localparam int SLen   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p = 1'b0, q = 1'b0, r = 1'b0, s = 1'b0;
  logic [1:0]  match, pass, fail, vacuous, busy;  // [0] first-match, [1] all-match
  logic [15:0] pass_cnt_a, fail_cnt_a;
  logic [1:0]  pass_cnt_b, fail_cnt_b;

  always #5 clk = ~clk;

  seq_first_match_checker #(
    .MIN_REP(MinRep), .MAX_REP(MaxRep), .S_LEN(SLen), .FIRST_MATCH(1'b1), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst(rst), .p(p), .q(q), .r(r), .s(s),
    .match(match[0]), .pass(pass[0]), .fail(fail[0]), .vacuous(vacuous[0]), .busy(busy[0]),
    .pass_cnt(pass_cnt_a), .fail_cnt(fail_cnt_a)
  );

  seq_first_match_checker #(
    .MIN_REP(MinRep), .MAX_REP(MaxRep), .S_LEN(SLen), .FIRST_MATCH(1'b0), .CNT_W(2)
  ) dut_b (
    .clk(clk), .rst(rst), .p(p), .q(q), .r(r), .s(s),
    .match(match[1]), .pass(pass[1]), .fail(fail[1]), .vacuous(vacuous[1]), .busy(busy[1]),
    .pass_cnt(pass_cnt_b), .fail_cnt(fail_cnt_b)
  );

  int passes = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Reference model: windows are a queue of remaining s-cycles, the attempt is a phase number.
  int     win [2][$];
  int     mode [2];     // 0 idle, 1 waiting for q, 2 counting q, 3 draining windows
  int     len [2];
  bit     matched [2];
  bit     e_match [2], e_pass [2], e_fail [2], e_vac [2];
  longint e_pcnt [2], e_fcnt [2];
  longint cmax [2];
  bit     model_ok = 1'b0;

  task automatic model_step(input int k);
    bit had;
    bit ep;
    e_match[k] = 1'b0;
    e_pass[k]  = 1'b0;
    e_fail[k]  = 1'b0;
    e_vac[k]   = 1'b0;
    if (rst) begin
      mode[k] = 0;
      win[k].delete();
      e_pcnt[k] = 0;
      e_fcnt[k] = 0;
      return;
    end
    had = (win[k].size() != 0);
    if (had) begin
      if (!s) begin
        e_fail[k] = 1'b1;
        win[k].delete();
        if (e_fcnt[k] < cmax[k]) e_fcnt[k]++;
      end else begin
        for (int i = 0; i < win[k].size(); i++) win[k][i] = win[k][i] - 1;
        if (win[k][0] == 0) begin
          void'(win[k].pop_front());
          e_pass[k] = 1'b1;
          if (e_pcnt[k] < cmax[k]) e_pcnt[k]++;
        end
      end
    end
    case (mode[k])
      0: if (p) mode[k] = 1;
      1: begin
        if (q) begin
          mode[k] = 2;
          len[k] = 1;
          matched[k] = 1'b0;
        end else begin
          e_vac[k] = 1'b1;
          mode[k] = 0;
        end
      end
      2: begin
        ep = r && (len[k] >= MinRep);
        if (ep) begin
          e_match[k] = 1'b1;
          matched[k] = 1'b1;
          win[k].push_back(SLen);
        end
        if (k == 0 && ep) mode[k] = 3;
        else if (q && len[k] < MaxRep) len[k]++;
        else if (had || ep) mode[k] = 3;
        else begin
          e_vac[k] = !matched[k];
          mode[k] = 0;
        end
      end
      default: if (win[k].size() == 0) mode[k] = 0;
    endcase
  endtask

  // Inputs change just after posedge, so at negedge they hold the values the next edge samples.
  always @(negedge clk) begin
    if (model_ok) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("cyc match[%0d]", k), 64'(match[k]), 64'(e_match[k]));
        chk($sformatf("cyc pass[%0d]", k), 64'(pass[k]), 64'(e_pass[k]));
        chk($sformatf("cyc fail[%0d]", k), 64'(fail[k]), 64'(e_fail[k]));
        chk($sformatf("cyc vacuous[%0d]", k), 64'(vacuous[k]), 64'(e_vac[k]));
        chk($sformatf("cyc busy[%0d]", k), 64'(busy[k]), 64'(mode[k] != 0));
        chk($sformatf("cyc pass_cnt[%0d]", k),
            (k == 0) ? 64'(pass_cnt_a) : 64'(pass_cnt_b), 64'(e_pcnt[k]));
        chk($sformatf("cyc fail_cnt[%0d]", k),
            (k == 0) ? 64'(fail_cnt_a) : 64'(fail_cnt_b), 64'(e_fcnt[k]));
      end
    end
    model_step(0);
    model_step(1);
    model_ok = 1'b1;
  end

  // obs[k][c] holds output value during cycle c of the current scenario.
  logic [63:0] om [2], op [2], ofl [2], ov [2], ob [2];

  task automatic run(input logic [63:0] pv, qv, rv, sv, rstv, input int n);
    for (int k = 0; k < 2; k++) begin
      om[k] = '0; op[k] = '0; ofl[k] = '0; ov[k] = '0; ob[k] = '0;
    end
    for (int c = 0; c <= n; c++) begin
      @(posedge clk);
      #2;
      for (int k = 0; k < 2; k++) begin
        om[k][c]  = match[k];
        op[k][c]  = pass[k];
        ofl[k][c] = fail[k];
        ov[k][c]  = vacuous[k];
        ob[k][c]  = busy[k];
      end
      rst = rstv[c];
      p   = pv[c];
      q   = qv[c];
      r   = rv[c];
      s   = sv[c];
    end
  endtask

  task automatic do_reset();
    run(64'h0, 64'h0, 64'h0, 64'h0, 64'h3, 2);
  endtask

  logic [63:0] pv6, qv6, rv6, sv6;

  initial begin
    cmax[0] = 65535;
    cmax[1] = 3;

    // Scenario 1: basic first-match pass.
    do_reset();
    run(64'h1, 64'hE, 64'h10, 64'h60, 64'h0, 10);
    chk("s1 match cycle5", om[0], 64'h20);
    chk("s1 pass cycle7", op[0], 64'h80);
    chk("s1 busy cycles1-6", ob[0], 64'h7E);
    chk("s1 no fail", ofl[0], 64'h0);
    chk("s1 pass_cnt", 64'(pass_cnt_a), 64'd1);

    // Scenario 2/3: overlapping endpoints, first-match vs all-match.
    do_reset();
    run(64'h1, 64'h1E, 64'h1C, 64'h38, 64'h0, 10);
    chk("s2 fm single match", om[0], 64'h08);
    chk("s2 fm pass", op[0], 64'h20);
    chk("s2 fm no fail", ofl[0], 64'h0);
    chk("s3 am matches", om[1], 64'h38);
    chk("s3 am passes", op[1], 64'h60);
    chk("s3 am fail cycle7", ofl[1], 64'h80);
    chk("s3 am pass_cnt", 64'(pass_cnt_b), 64'd2);
    chk("s3 am fail_cnt", 64'(fail_cnt_b), 64'd1);

    // Scenario 4a: no q after p.
    do_reset();
    run(64'h1, 64'h0, 64'h0, 64'h0, 64'h0, 5);
    chk("s4a vacuous fm", ov[0], 64'h4);
    chk("s4a vacuous am", ov[1], 64'h4);

    // Scenario 4b: q run hits MAX_REP, r never arrives.
    do_reset();
    run(64'h1, 64'h1E, 64'h0, 64'h0, 64'h0, 8);
    chk("s4b vacuous fm", ov[0], 64'h20);
    chk("s4b vacuous am", ov[1], 64'h20);
    chk("s4b no match", om[0] | om[1], 64'h0);
    chk("s4b pass_cnt", 64'(pass_cnt_a), 64'd0);

    // Scenario 5: p held high is one attempt; reset mid-run discards the second attempt.
    do_reset();
    run(64'h47F, 64'h180E, 64'h10, 64'h28060, 64'h2000, 20);
    chk("s5 one match", om[0], 64'h20);
    chk("s5 one pass", op[0], 64'h80);
    chk("s5 busy first", 64'(ob[0][7:0]), 64'h7E);
    chk("s5 busy second", 64'(ob[0][19:8]), 64'h038);
    chk("s5 quiet after rst", (om[0] | op[0] | ofl[0] | ov[0] | om[1] | op[1]) >> 14, 64'h0);
    chk("s5 pass_cnt cleared", 64'(pass_cnt_a), 64'd0);

    // Scenario 6: five passing attempts saturate the 2-bit counter.
    pv6 = '0; qv6 = '0; rv6 = '0; sv6 = '0;
    for (int a = 0; a < 5; a++) begin
      pv6[5*a] = 1'b1;
      qv6[5*a+1] = 1'b1;
      rv6[5*a+2] = 1'b1;
      sv6[5*a+3] = 1'b1;
      sv6[5*a+4] = 1'b1;
    end
    do_reset();
    run(pv6, qv6, rv6, sv6, 64'h0, 27);
    chk("s6 saturated pass_cnt", 64'(pass_cnt_b), 64'd3);
    chk("s6 wide pass_cnt", 64'(pass_cnt_a), 64'd5);
    chk("s6 no fails", 64'(fail_cnt_a) + 64'(fail_cnt_b), 64'd0);

    run(64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 3);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seq_first_match_checker.md
Name: seq_first_match_checker

Overview:
- Synthesizable hardware monitor for the temporal property `p ##1 q[*MIN_REP:MAX_REP] ##1 r |=> s[*S_LEN]`.
- Antecedent resolution is selectable: first-match or all-match.
- Sits beside DUT interfaces as an in-silicon checker. It reports pass, fail, vacuous and match events, and keeps saturating pass/fail counters readable by software or the testbench.
- It is the RTL counterpart of our SVA first_match experiments, generalised in repetition range, consequent length and match mode.

Parameters:
- MIN_REP, 1, minimum consecutive q cycles; legal range 1 ≤ MIN_REP ≤ MAX_REP.
- MAX_REP, 3, maximum consecutive q cycles.
- S_LEN, 2, consecutive cycles s must hold after each antecedent match; must be ≥ 1.
- FIRST_MATCH, 1, match mode: 1 = first-match (one consequent check per attempt); 0 = all-match (every antecedent endpoint launches a consequent check).
- CNT_W, 16, width of the event counters.

Ports:
- clk  in  1  single clock; all sampling on posedge.
- rst  in  1  synchronous, active-high reset.
- p  in  1  attempt-start signal.
- q  in  1  repeated signal.
- r  in  1  antecedent terminator.
- s  in  1  consequent signal.
- match  out  1  one-cycle pulse: antecedent endpoint detected.
- pass  out  1  one-cycle pulse: one consequent window completed with s high throughout.
- fail  out  1  one-cycle pulse: s sampled low while any consequent window is pending.
- vacuous  out  1  one-cycle pulse: attempt abandoned without any match.
- busy  out  1  high whenever state ≠ IDLE.
- pass_cnt  out  CNT_W  saturating count of pass pulses.
- fail_cnt  out  CNT_W  saturating count of fail pulses.

Behaviour:
- **Timing convention.** "Sample c" means input values at posedge c. All outputs are registered: an event detected at sample c is visible during cycle c+1.
- **Reset.** With rst high at a posedge, at that edge: state goes to IDLE, rep and pend are cleared, all pulses go to 0, busy goes to 0, both counters go to 0. Reset mid-attempt discards the attempt with no pass, fail or vacuous pulse. rst has priority over every input.
- **State machine.** States are IDLE, ARMED, QRUN, CHECK. rep is a counter 0..MAX_REP. pend is an S_LEN-bit shift register of outstanding consequent windows.
- **IDLE.**
  - p=1 → ARMED.
  - p is sampled only in IDLE. p in any other state is ignored, so there is a single attempt thread with no overlap.
- **ARMED.**
  - q=1 → rep=1, go to QRUN.
  - q=0 → vacuous pulse, go to IDLE.
- **QRUN.** At each sample, with rep = q-run length so far, evaluate in this order:
  - **Endpoint.** `ep = r && rep >= MIN_REP`. If ep, raise a match pulse and set pend[0] (the window starts at the next sample).
  - **First-match mode (FIRST_MATCH=1).** If ep, go to CHECK; q is ignored for this sample.
  - **Extend.** Otherwise (and always in all-match mode): if q=1 and rep < MAX_REP, then rep += 1 and stay in QRUN.
  - **Run ends.** Otherwise the run is over:
    - if pend ≠ 0 or ep, go to CHECK;
    - else raise a vacuous pulse and go to IDLE (only if no match occurred in this attempt).
- **Consequent check (any state with pend ≠ 0).**
  - s=0 → fail pulse, pend cleared, fail_cnt += 1. This is one fail per event, however many windows were pending.
  - s=1 → pend shifts up one bit. A bit leaving pend[S_LEN-1] raises a pass pulse and pass_cnt += 1.
  - The new pend[0] from an endpoint at the same sample is inserted after the shift.
- **CHECK.** When pend becomes 0 (last window passed or fail occurred) and the state is not QRUN, go to IDLE. p at that same sample is ignored.
- **Overlapping passes (all-match mode).** Windows may overlap, so pass can pulse on consecutive cycles. Only one window completes per cycle because endpoints are at most one per cycle.
- **Counters.** pass_cnt and fail_cnt saturate at 2^CNT_W − 1 and do not wrap.
- **Mutual exclusion.** match, pass and fail may coincide. vacuous never coincides with match or pass.

Test Plan:
1. FIRST_MATCH=1. Stimulus: p@0, q@1–3, r@4, s@5–6. Response: match in cycle 5, pass in cycle 7, busy high cycles 1–6, pass_cnt=1, no fail.
2. FIRST_MATCH=1. Stimulus: p@0, q@1–4, r@2–4, s@3–5. Response: single match in cycle 3, pass in cycle 5, no fail. The later r samples are ignored.
3. FIRST_MATCH=0, same stimulus as scenario 2. Response: match in cycles 3, 4, 5; pass in cycles 5 and 6; s low at sample 6 with a window pending → fail in cycle 7; pass_cnt=2, fail_cnt=1.
4. Vacuity. Stimulus (a): p@0, q low @1. Stimulus (b): p@0, q@1–4, r never. Response: vacuous pulse in cycle 2 for (a) and cycle 5 for (b) (q run capped at MAX_REP); no match; counters unchanged.
5. Reset and ignored p. Stimulus: p held high throughout scenario 1 → exactly one attempt. Then assert rst mid-QRUN → busy=0 next cycle, counters 0, no pulses afterwards until a new p.
6. Saturation. Stimulus: CNT_W=2 with 5 passing attempts. Response: pass_cnt stops at 3.
